// File: rtl/branch_predictor.sv
// branch_predictor
//   IF-stage dynamic branch predictor: a direct-mapped BTB with 2-bit
//   saturating counters. It looks up if_pc combinationally and resolves the
//   branch in EX combinationally. The tables update on the clock edge at
//   which EX holds a branch.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   if_pc                 fetch PC to predict
//   pred_taken            predicted taken for if_pc
//   pred_target           predicted target (0 when not taken)
//   ex_branch             EX holds a valid conditional branch
//   ex_pc, ex_taken,
//   ex_target             resolved branch PC, outcome and target
//   ex_pred_taken,
//   ex_pred_target        prediction carried down the pipe for that branch
//   mispredict            flush IF/ID and ID/EX
//   redirect_pc           correct next PC (0 unless mispredict)
//   stat_branches,
//   stat_mispred          only when BP_STATS_EN is defined: wrapping
//                         counters of resolved branches and mispredicts
//
// Configuration macro: BP_STATS_EN (adds the statistics counters/ports).
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]      target_q, target_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  // Instruction-alignment bits play no part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  // Lookup reads the registered tables, so a same-cycle update to the same
  // entry becomes visible only on the following cycle.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : 32'h0;
  end

  always_comb begin
    mispredict  = ex_branch && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_target != ex_pred_target)));
    redirect_pc = 32'h0;
    if (mispredict) redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (ex_branch) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = ex_target;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        // Allocate (or evict an aliasing entry) as weakly taken. A not-taken
        // miss is left alone so it does not evict useful entries.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{2'b01}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q + {31'd0, ex_branch};
    stat_mispred_d  = stat_mispred_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_branch = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] nbr;
    logic [31:0] nmp;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] cnt_br = 0;
  logic [31:0] cnt_mp = 0;

  task automatic chk(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", name, fld, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each pushed expectation is
  // compared mid-cycle, away from the clock edge that may update state.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
      chk(e.name, "pred_target", pred_target, e.tgt);
      chk(e.name, "mispredict", {31'd0, mispredict}, {31'd0, e.mp});
      chk(e.name, "redirect_pc", redirect_pc, e.rpc);
`ifdef BP_STATS_EN
      chk(e.name, "stat_branches", stat_branches, e.nbr);
      chk(e.name, "stat_mispred", stat_mispred, e.nmp);
`endif
    end
  end

  task automatic push(input string name, input logic pt, input logic [31:0] tgt,
                      input logic mp, input logic [31:0] rpc);
    exp_t e;
    e.name = name; e.pt = pt; e.tgt = tgt; e.mp = mp; e.rpc = rpc;
    e.nbr = cnt_br; e.nmp = cnt_mp;
    exp_q.push_back(e);
  endtask

  // Inputs are applied 1 time unit after a posedge; the call returns at the
  // same phase of the next cycle.
  task automatic lookup(input string name, input logic [31:0] ipc,
                        input logic ept, input logic [31:0] etgt);
    if_pc = ipc; ex_branch = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0;
    ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    push(name, ept, etgt, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic resolve(input string name, input logic [31:0] ipc,
                         input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ppt,
                         input logic [31:0] ptgt, input logic ept,
                         input logic [31:0] etgt, input logic emp,
                         input logic [31:0] erpc);
    if_pc = ipc; ex_branch = 1'b1; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ppt; ex_pred_target = ptgt;
    push(name, ept, etgt, emp, erpc);
    cnt_br = cnt_br + 32'd1;
    if (emp) cnt_mp = cnt_mp + 32'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // T1: reset holds every entry invalid
    for (int i = 0; i < 16; i++) lookup("t1_rst", 32'h100 + 32'(i * 4), 1'b0, 32'h0);
    reset = 1'b0;
    lookup("t1_post", 32'h100, 1'b0, 32'h0);

    // T2: allocate 0x100 -> 0x80
    resolve("t2_alloc", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'h80);
    lookup("t2_hit", 32'h100, 1'b1, 32'h80);

    // T3: two not-taken resolves, 10 -> 01 -> 00
    resolve("t3_nt1", 32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80,
            1'b1, 32'h80, 1'b1, 32'h104);
    lookup("t3_weak", 32'h100, 1'b0, 32'h0);
    resolve("t3_nt2", 32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b0, 32'h0);
    // 00 -> 01 still predicts not taken (would be 10 if nt2 had not decremented)
    resolve("t3_tk", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'h80);
    lookup("t3_sat0", 32'h100, 1'b0, 32'h0);

    // T4: 0x200 (same index as 0x100) trained to strongly taken
    resolve("t4_tk1", 32'h200, 32'h200, 1'b1, 32'h240, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'h240);
    resolve("t4_tk2", 32'h200, 32'h200, 1'b1, 32'h240, 1'b1, 32'h240,
            1'b1, 32'h240, 1'b0, 32'h0);
    resolve("t4_tk3", 32'h200, 32'h200, 1'b1, 32'h240, 1'b1, 32'h240,
            1'b1, 32'h240, 1'b0, 32'h0);
    resolve("t4_tk4", 32'h200, 32'h200, 1'b1, 32'h240, 1'b1, 32'h240,
            1'b1, 32'h240, 1'b0, 32'h0);
    resolve("t4_nt", 32'h200, 32'h200, 1'b0, 32'h240, 1'b1, 32'h240,
            1'b1, 32'h240, 1'b1, 32'h204);
    lookup("t4_still", 32'h200, 1'b1, 32'h240);
    // taken, right direction but wrong target
    resolve("t4_tgt", 32'h200, 32'h200, 1'b1, 32'h280, 1'b1, 32'h240,
            1'b1, 32'h240, 1'b1, 32'h280);
    lookup("t4_newtgt", 32'h200, 1'b1, 32'h280);

    // T5: aliasing at index 0
    resolve("t5_0x100", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'h80);
    lookup("t5_hit100", 32'h100, 1'b1, 32'h80);
    lookup("t5_miss140", 32'h140, 1'b0, 32'h0);
    lookup("t5_miss200", 32'h200, 1'b0, 32'h0);
    resolve("t5_0x140", 32'h140, 32'h140, 1'b1, 32'h500, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'h500);
    lookup("t5_evict100", 32'h100, 1'b0, 32'h0);
    lookup("t5_hit140", 32'h140, 1'b1, 32'h500);
    // not-taken miss must not allocate or evict
    resolve("t5_ntmiss", 32'h140, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0,
            1'b1, 32'h500, 1'b0, 32'h0);
    lookup("t5_lsb", 32'h143, 1'b1, 32'h500);
    lookup("t5_100miss", 32'h100, 1'b0, 32'h0);

    // PC wrap on not-taken redirect; no allocation on not-taken miss
    resolve("wrap", 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 32'h10, 1'b1, 32'h10,
            1'b0, 32'h0, 1'b1, 32'h0);
    lookup("wrap_noalloc", 32'hFFFFFFFC, 1'b0, 32'h0);

    // ex_branch=0: no mispredict and no update even with taken inputs
    if_pc = 32'h604; ex_branch = 1'b0; ex_pc = 32'h604; ex_taken = 1'b1;
    ex_target = 32'h900; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    push("noexb", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    lookup("noexb_upd", 32'h604, 1'b0, 32'h0);

    // T6: same-cycle lookup/update sees old contents
    resolve("t6_same", 32'h300, 32'h300, 1'b1, 32'h340, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'h340);
    lookup("t6_next", 32'h300, 1'b1, 32'h340);
    // asynchronous reset mid-cycle
    reset = 1'b1;
    cnt_br = 0; cnt_mp = 0;
    lookup("t6_rst", 32'h300, 1'b0, 32'h0);
    reset = 1'b0;
    lookup("t6_after", 32'h300, 1'b0, 32'h0);
    lookup("t6_after140", 32'h140, 1'b0, 32'h0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
